// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared constants and parameter helpers for sync_fifo_flex
package sync_fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // Pointers carry one extra wrap bit above the address.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit params_legal(input int depth, input int af_thresh, input int ae_thresh);
        return (depth >= 2) && ((depth & (depth - 1)) == 0)
            && (af_thresh >= 0) && (af_thresh <= depth)
            && (ae_thresh >= 0) && (ae_thresh <= depth);
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// rtl/fifo_mem_2p.sv - storage array with one synchronous write port and one asynchronous read port
module fifo_mem_2p
    import sync_fifo_pkg::*;
#(
    parameter int data_width = 32,
    parameter int fifo_depth = 8
) (
    input  logic                            clk,
    input  logic                            wr_en,
    input  logic [$clog2(fifo_depth)-1:0]   wr_addr,
    input  logic [data_width-1:0]           wr_data,
    input  logic [$clog2(fifo_depth)-1:0]   rd_addr,
    output logic [data_width-1:0]           rd_data
);

    logic [data_width-1:0] mem_q [fifo_depth];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo_flex.sv
// rtl/sync_fifo_flex.sv - single-clock FIFO with selectable read mode, threshold flags and sticky errors
module sync_fifo_flex
    import sync_fifo_pkg::*;
#(
    parameter int data_width          = 32,
    parameter int fifo_depth          = 8,
    parameter int fwft                = 0,
    parameter int almost_full_thresh  = fifo_depth - 2,
    parameter int almost_empty_thresh = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cs,
    input  logic                            flush,
    input  logic                            wr_en,
    input  logic                            rd_en,
    input  logic [data_width-1:0]           data_in,
    output logic [data_width-1:0]           data_out,
    output logic                            empty,
    output logic                            full,
    output logic                            almost_empty,
    output logic                            almost_full,
    output logic [$clog2(fifo_depth):0]     count,
    output logic                            overflow,
    output logic                            underflow
);

    localparam int AW = $clog2(fifo_depth);
    localparam int PW = ptr_width(fifo_depth);
    localparam logic [PW-1:0] AF_T = PW'(almost_full_thresh);
    localparam logic [PW-1:0] AE_T = PW'(almost_empty_thresh);

    if (!params_legal(fifo_depth, almost_full_thresh, almost_empty_thresh)) begin : g_param_check
        $error("sync_fifo_flex: illegal depth or threshold parameters");
    end

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  rd_acc, wr_acc, mem_we;
    logic [data_width-1:0] mem_rd;

    assign empty        = (wr_ptr_q == rd_ptr_q);
    assign full         = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign count        = wr_ptr_q - rd_ptr_q;
    assign almost_full  = (count >= AF_T);
    assign almost_empty = (count <= AE_T);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A concurrent read frees a slot, so a full FIFO can still take a write.
    assign rd_acc = cs & rd_en & ~empty;
    assign wr_acc = cs & wr_en & (~full | rd_acc);
    assign mem_we = wr_acc & ~flush;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
            if (cs & wr_en & ~wr_acc) overflow_d = 1'b1;
            if (cs & rd_en & empty) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem_2p #(
        .data_width (data_width),
        .fifo_depth (fifo_depth)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_data (data_in),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_data (mem_rd)
    );

    if (fwft == FIFO_FWFT) begin : g_fwft
        assign data_out = empty ? '0 : mem_rd;
    end else begin : g_std
        logic [data_width-1:0] dout_q, dout_d;

        always_comb begin
            dout_d = dout_q;
            if (flush) begin
                dout_d = '0;
            end else if (rd_acc) begin
                dout_d = mem_rd;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                dout_q <= '0;
            end else begin
                dout_q <= dout_d;
            end
        end

        assign data_out = dout_q;
    end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb/tb_sync_fifo_flex.sv - scoreboard bench driving standard and FWFT instances in lockstep
module tb_sync_fifo_flex;

    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cs, flush, wr_en, rd_en;
    logic [DW-1:0] data_in;

    logic [DW-1:0] dout_s, dout_f;
    logic          empty_s, full_s, aempty_s, afull_s, ovf_s, unf_s;
    logic          empty_f, full_f, aempty_f, afull_f, ovf_f, unf_f;
    logic [3:0]    count_s, count_f;

    int            n_checks = 0;
    int            n_errors = 0;

    logic [DW-1:0] sb_q[$];
    logic          m_ovf, m_unf;
    logic [DW-1:0] m_dstd;

    always #5 clk = ~clk;

    sync_fifo_flex #(
        .data_width (DW), .fifo_depth (DEPTH), .fwft (0),
        .almost_full_thresh (6), .almost_empty_thresh (1)
    ) u_std (
        .clk (clk), .rst (rst), .cs (cs), .flush (flush),
        .wr_en (wr_en), .rd_en (rd_en), .data_in (data_in), .data_out (dout_s),
        .empty (empty_s), .full (full_s), .almost_empty (aempty_s), .almost_full (afull_s),
        .count (count_s), .overflow (ovf_s), .underflow (unf_s)
    );

    sync_fifo_flex #(
        .data_width (DW), .fifo_depth (DEPTH), .fwft (1),
        .almost_full_thresh (6), .almost_empty_thresh (1)
    ) u_fwft (
        .clk (clk), .rst (rst), .cs (cs), .flush (flush),
        .wr_en (wr_en), .rd_en (rd_en), .data_in (data_in), .data_out (dout_f),
        .empty (empty_f), .full (full_f), .almost_empty (aempty_f), .almost_full (afull_f),
        .count (count_f), .overflow (ovf_f), .underflow (unf_f)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_dstd = '0;
    endtask

    task automatic check_all();
        int            n;
        logic [DW-1:0] head;
        n    = sb_q.size();
        head = (n != 0) ? sb_q[0] : '0;
        check("std.count",  32'(count_s),  32'(n));
        check("std.empty",  32'(empty_s),  32'(n == 0));
        check("std.full",   32'(full_s),   32'(n == DEPTH));
        check("std.aempty", 32'(aempty_s), 32'(n <= 1));
        check("std.afull",  32'(afull_s),  32'(n >= 6));
        check("std.ovf",    32'(ovf_s),    32'(m_ovf));
        check("std.unf",    32'(unf_s),    32'(m_unf));
        check("std.dout",   dout_s,        m_dstd);
        check("fwft.count", 32'(count_f),  32'(n));
        check("fwft.empty", 32'(empty_f),  32'(n == 0));
        check("fwft.full",  32'(full_f),   32'(n == DEPTH));
        check("fwft.ovf",   32'(ovf_f),    32'(m_ovf));
        check("fwft.unf",   32'(unf_f),    32'(m_unf));
        check("fwft.dout",  dout_f,        head);
    endtask

    // One clock: drive at posedge+1, sample at the next posedge+1.
    task automatic cyc(input logic c, input logic w, input logic r, input logic [DW-1:0] d, input logic f);
        int n;
        bit racc, wacc;
        cs = c; wr_en = w; rd_en = r; data_in = d; flush = f;
        n    = sb_q.size();
        racc = c && r && (n != 0);
        wacc = c && w && ((n < DEPTH) || racc);
        @(posedge clk);
        #1;
        if (f) begin
            model_reset();
        end else begin
            if (c && w && !wacc) m_ovf = 1'b1;
            if (c && r && n == 0) m_unf = 1'b1;
            if (racc) m_dstd = sb_q.pop_front();
            if (wacc) sb_q.push_back(d);
        end
        cs = 1'b0; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
        check_all();
    endtask

    initial begin
        rst = 1'b0; cs = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check_all();

        for (int i = 0; i < 8; i++) cyc(1, 1, 0, 32'hA0 + i, 0);
        cyc(1, 1, 0, 32'hFF, 0);
        for (int i = 0; i < 9; i++) cyc(1, 0, 1, '0, 0);

        cyc(0, 0, 0, '0, 1);
        cyc(0, 1, 1, 32'h77, 0);
        cyc(1, 1, 0, 32'h55, 0);
        cyc(1, 0, 1, '0, 0);

        cyc(0, 0, 0, '0, 1);
        for (int i = 0; i < 8; i++) cyc(1, 1, 0, 32'h100 + i, 0);
        for (int i = 0; i < 20; i++) cyc(1, 1, 1, 32'h200 + i, 0);
        for (int i = 0; i < 8; i++) cyc(1, 0, 1, '0, 0);

        cyc(0, 0, 0, '0, 1);
        cyc(1, 1, 1, 32'h33, 0);
        cyc(1, 0, 1, '0, 0);

        cyc(0, 0, 0, '0, 1);
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 32'h300 + i, 0);
        cyc(1, 1, 0, 32'hEE, 1);
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 32'h400 + i, 0);
        cyc(1, 0, 1, '0, 0);

        cs = 1'b1; wr_en = 1'b1; data_in = 32'h500;
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        cs = 1'b0; wr_en = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check_all();

        for (int i = 0; i < 80; i++) begin
            cyc($urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom), $urandom, $urandom_range(0, 24) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
